// File: rtl/video_fetch_shifter_if.sv
// Memory-side bus of the text fetch stage: video RAM read port and char ROM read port.
interface video_fetch_shifter_if;
  logic [15:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_data;
  logic [10:0] rom_addr;
  logic [7:0]  rom_data;

  modport master (
    output vram_addr,
    output vram_rd,
    output rom_addr,
    input  vram_data,
    input  rom_data
  );

  modport slave (
    input  vram_addr,
    input  vram_rd,
    input  rom_addr,
    output vram_data,
    output rom_data
  );
endinterface

// File: rtl/video_fetch_shifter.sv
// Text-mode fetch/serialise stage: per 8-pixel cell reads a char code, then a glyph row,
// and shifts it out MSB-first with syncs and blanks delayed by the same 8 pixels.
module video_fetch_shifter #(
  parameter int unsigned CHAR_ROWS = 10,
  parameter int unsigned TEXT_ROWS = 24,
  parameter int unsigned TEXT_COLS = 52,
  parameter logic [3:0]  VRAM_BASE = 4'hF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         ce_pix,
  input  logic                         hblank_i,
  input  logic                         vblank_i,
  input  logic                         hsync_i,
  input  logic                         vsync_i,
  video_fetch_shifter_if.master        mem,
  output logic                         hblank_o,
  output logic                         vblank_o,
  output logic                         hsync_o,
  output logic                         vsync_o,
  output logic [7:0]                   video
);

  localparam logic [3:0] LAST_LINE = 4'(CHAR_ROWS - 1);
  localparam logic [5:0] ROW_LIMIT = 6'(TEXT_ROWS);
  localparam logic [7:0] COL_LIMIT = 8'(TEXT_COLS);

  logic [2:0]       ph_r;
  logic [6:0]       col_r;
  logic [3:0]       char_line_r;
  logic [5:0]       text_row_r;
  logic             hblank_prev_r;
  logic             inv_r;
  logic             fetch_ok_r;
  logic [7:0]       glyph_r;
  logic [7:0]       shifter_r;
  logic [7:0]       video_r;
  logic [7:0][3:0]  dly_r;
  logic [15:0]      vram_addr_r;
  logic             vram_rd_r;
  logic [10:0]      rom_addr_r;

  logic             fetch_slot_s;
  logic             in_range_s;
  logic             load_s;
  logic [7:0]       shifter_nxt_s;
  logic [7:0]       video_nxt_s;

  // Fetches only start on real active pixels, so blanking never issues reads.
  assign fetch_slot_s = ce_pix & (ph_r == 3'd0) & ~hblank_i & ~vblank_i;
  assign in_range_s   = ({1'b0, col_r} < COL_LIMIT) & (text_row_r < ROW_LIMIT);
  assign load_s       = (ph_r == 3'd7) & ~hblank_i;

  // Next shifter contents and the pixel value derived from them.
  always_comb begin
    shifter_nxt_s = {shifter_r[6:0], 1'b0};
    video_nxt_s   = 8'h00;
    if (load_s) begin
      shifter_nxt_s = fetch_ok_r ? glyph_r : 8'h00;
    end else begin
      shifter_nxt_s = {shifter_r[6:0], 1'b0};
    end
    if (shifter_nxt_s[7] && !dly_r[6][1] && !dly_r[6][0]) begin
      video_nxt_s = 8'hFF;
    end else begin
      video_nxt_s = 8'h00;
    end
  end

  // Pixel phase, cell column, glyph line and text row counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      ph_r          <= 3'd0;
      col_r         <= 7'd0;
      char_line_r   <= 4'd0;
      text_row_r    <= 6'd0;
      hblank_prev_r <= 1'b0;
    end else if (ce_pix) begin
      hblank_prev_r <= hblank_i;
      if (vblank_i) begin
        char_line_r <= 4'd0;
        text_row_r  <= 6'd0;
      end else if (hblank_i && !hblank_prev_r) begin
        if (char_line_r == LAST_LINE) begin
          char_line_r <= 4'd0;
          if (text_row_r < ROW_LIMIT) begin
            text_row_r <= text_row_r + 6'd1;
          end
        end else begin
          char_line_r <= char_line_r + 4'd1;
        end
      end
      if (hblank_i) begin
        ph_r  <= 3'd0;
        col_r <= 7'd0;
      end else begin
        ph_r <= ph_r + 3'd1;
        if (ph_r == 3'd7 && col_r != 7'd127) begin
          col_r <= col_r + 7'd1;
        end
      end
    end
  end

  // Read strobe is re-evaluated every clk so it lasts exactly one clk even with sparse ce_pix.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_rd_r <= 1'b0;
    end else begin
      vram_rd_r <= fetch_slot_s & in_range_s;
    end
  end

  // Cell pipeline: address, code, glyph, shifter, pixel and the matching delay line.
  always_ff @(posedge clk) begin
    if (reset) begin
      vram_addr_r <= 16'h0000;
      rom_addr_r  <= 11'h000;
      inv_r       <= 1'b0;
      fetch_ok_r  <= 1'b0;
      glyph_r     <= 8'h00;
      shifter_r   <= 8'h00;
      video_r     <= 8'h00;
      dly_r       <= '0;
    end else if (ce_pix) begin
      if (fetch_slot_s) begin
        vram_addr_r <= {VRAM_BASE, text_row_r[4:0], col_r};
      end
      if (ph_r == 3'd0 && !hblank_i) begin
        fetch_ok_r <= ~vblank_i & in_range_s;
      end
      case (ph_r)
        3'd2: begin
          inv_r      <= mem.vram_data[7];
          rom_addr_r <= {char_line_r, mem.vram_data[6:0]};
        end
        3'd4:    glyph_r <= mem.rom_data ^ {8{inv_r}};
        default: ;
      endcase
      shifter_r <= shifter_nxt_s;
      video_r   <= video_nxt_s;
      dly_r     <= {dly_r[6:0], {vsync_i, hsync_i, vblank_i, hblank_i}};
    end
  end

  assign mem.vram_addr = vram_addr_r;
  assign mem.vram_rd   = vram_rd_r;
  assign mem.rom_addr  = rom_addr_r;
  assign hblank_o      = dly_r[7][0];
  assign vblank_o      = dly_r[7][1];
  assign hsync_o       = dly_r[7][2];
  assign vsync_o       = dly_r[7][3];
  assign video         = video_r;

endmodule

// File: tb/tb_video_fetch_shifter.sv
// Scoreboard bench for video_fetch_shifter: stimulus pushes expected reads and pixels,
// monitors pop and compare as the DUT presents them.
module tb_video_fetch_shifter;
  localparam int ACT  = 64;
  localparam int HBL  = 16;
  localparam int COLS = 8;
  localparam int VBL  = 4;

  logic       clk = 1'b0;
  logic       reset, ce_pix, hblank_i, vblank_i, hsync_i, vsync_i;
  logic       hblank_o, vblank_o, hsync_o, vsync_o;
  logic [7:0] video;

  video_fetch_shifter_if mem_bus();

  video_fetch_shifter #(.TEXT_COLS(COLS)) dut (
    .clk(clk), .reset(reset), .ce_pix(ce_pix),
    .hblank_i(hblank_i), .vblank_i(vblank_i), .hsync_i(hsync_i), .vsync_i(vsync_i),
    .mem(mem_bus.master),
    .hblank_o(hblank_o), .vblank_o(vblank_o), .hsync_o(hsync_o), .vsync_o(vsync_o),
    .video(video)
  );

  always #5 clk = ~clk;

  logic [7:0] vram_mem [0:4095];
  logic [7:0] rom_mem  [0:2047];

  always @(posedge clk) begin
    if (reset) mem_bus.vram_data <= 8'h00;
    else if (mem_bus.vram_rd) mem_bus.vram_data <= vram_mem[mem_bus.vram_addr[11:0]];
  end
  always @(posedge clk) mem_bus.rom_data <= rom_mem[mem_bus.rom_addr];

  int checks = 0;
  int errors = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  typedef struct packed {logic [15:0] va; logic [10:0] ra;} rd_t;
  typedef struct {int line; int px; logic [7:0] v;} pix_t;
  rd_t  rd_q[$];
  pix_t pq[$];

  logic rd_en = 1'b0, pix_en = 1'b0, sync_en = 1'b0;
  int   ce_div = 1;

  // Read monitor: address on each strobe, strobe width, rom_addr two ce later.
  logic        pend = 1'b0, prev_rd = 1'b0;
  int          rcnt = 0;
  logic [10:0] exp_ra = 11'h000;
  rd_t         re;
  always @(negedge clk) begin
    if (!rd_en) begin
      pend = 1'b0;
      prev_rd = 1'b0;
    end else begin
      if (prev_rd) chk("vram_rd_width", mem_bus.vram_rd, 32'd0);
      if (pend) begin
        if (rcnt == 0) begin
          chk("rom_addr", mem_bus.rom_addr, exp_ra);
          pend = 1'b0;
        end else if (ce_pix) rcnt--;
      end
      if (mem_bus.vram_rd) begin
        if (rd_q.size() == 0) chk("vram_rd_unexpected", 32'd1, 32'd0);
        else begin
          re = rd_q.pop_front();
          chk("vram_addr", mem_bus.vram_addr, re.va);
          exp_ra = re.ra;
          pend = 1'b1;
          rcnt = ce_pix ? 1 : 2;
        end
      end
      prev_rd = mem_bus.vram_rd;
    end
  end

  // Pixel monitor: tracks output line/pixel from delayed blanks, pops matching expectations.
  int   oline = 0, opx = 0;
  logic seen = 1'b0;
  pix_t pe;
  always @(negedge clk) begin
    if (pix_en && ce_pix) begin
      if (vblank_o) begin
        oline = 0; opx = 0; seen = 1'b0;
        chk("video_vblank", video, 32'd0);
      end else if (hblank_o) begin
        if (seen) oline++;
        seen = 1'b0; opx = 0;
        chk("video_hblank", video, 32'd0);
      end else begin
        if (pq.size() > 0 && pq[0].line == oline && pq[0].px == opx) begin
          pe = pq.pop_front();
          chk($sformatf("video_l%0d_p%0d", oline, opx), video, pe.v);
        end
        opx++;
        seen = 1'b1;
      end
    end
  end

  // Sync delay monitor: outputs must equal inputs from 16 clks earlier at half-rate ce.
  logic [31:0] hhist = '0, vhist = '0;
  int          scnt = 0;
  always @(negedge clk) begin
    hhist = {hhist[30:0], hsync_i};
    vhist = {vhist[30:0], vsync_i};
    if (sync_en) begin
      scnt++;
      if (scnt > 40) begin
        chk("hsync_dly16", hsync_o, hhist[16]);
        chk("vsync_dly16", vsync_o, vhist[16]);
      end
    end else scnt = 0;
  end

  task automatic tick(input logic hb, input logic vb, input logic hs, input logic vs);
    hblank_i = hb; vblank_i = vb; hsync_i = hs; vsync_i = vs;
    if (ce_div == 2) begin
      ce_pix = 1'b0;
      @(posedge clk); #1;
    end
    ce_pix = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_vram_addr"}, mem_bus.vram_addr, 32'd0);
    chk({tag, "_vram_rd"},   mem_bus.vram_rd,   32'd0);
    chk({tag, "_rom_addr"},  mem_bus.rom_addr,  32'd0);
    chk({tag, "_hblank_o"},  hblank_o, 32'd0);
    chk({tag, "_vblank_o"},  vblank_o, 32'd0);
    chk({tag, "_hsync_o"},   hsync_o,  32'd0);
    chk({tag, "_vsync_o"},   vsync_o,  32'd0);
    chk({tag, "_video"},     video,    32'd0);
  endtask

  task automatic mid_reset();
    rd_en = 1'b0; pix_en = 1'b0;
    rd_q.delete(); pq.delete();
    reset = 1'b1; ce_pix = 1'b1;
    @(posedge clk); #1;
    check_all_zero("rst_mid");
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic drive_line(input logic vb, input logic vs, input int rst_px);
    for (int p = 0; p < ACT; p++) begin
      if (p == rst_px) mid_reset();
      tick(1'b0, vb, 1'b0, vs);
    end
    for (int p = 0; p < HBL; p++) tick(1'b1, vb, (p >= 4 && p < 10), vs);
  endtask

  task automatic push_rd(input int l);
    logic [15:0] a;
    if (l < 240) begin
      for (int c = 0; c < COLS; c++) begin
        a = 16'hF000 | 16'((l / 10) << 7) | 16'(c);
        rd_q.push_back({a, 4'(l % 10), vram_mem[a[11:0]][6:0]});
      end
    end
  endtask

  // Expected pixels for one output line: glyph byte g0 in cell 0, g7 in cell 7, zeros between.
  task automatic push_line(input int line, input logic [7:0] g0, input logic [7:0] g7);
    logic [7:0] g;
    for (int px = 0; px < ACT; px++) begin
      g = (px < 8) ? g0 : (px >= 56) ? g7 : 8'h00;
      pq.push_back('{line, px, g[7 - (px % 8)] ? 8'hFF : 8'h00});
    end
  endtask

  task automatic frame(input int nlines);
    for (int v = 0; v < VBL; v++) drive_line(1'b1, (v == 1), -1);
    for (int l = 0; l < nlines; l++) begin
      push_rd(l);
      drive_line(1'b0, 1'b0, -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) vram_mem[i] = 8'h00;
    for (int i = 0; i < 2048; i++) rom_mem[i] = 8'h00;
    rom_mem[11'h041] = 8'h3C;
    rom_mem[11'h0C1] = 8'h81;
    rom_mem[11'h4C2] = 8'hF0;
    vram_mem[12'h000] = 8'h41;
    vram_mem[12'h007] = 8'h41;

    reset = 1'b1; ce_pix = 1'b0;
    hblank_i = 1'b1; vblank_i = 1'b1; hsync_i = 1'b0; vsync_i = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check_all_zero("reset");
    reset = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 2; i++) drive_line(1'b1, 1'b0, -1);
    pix_en = 1'b1;

    // Plain attribute, char line 0 and 1
    push_line(0, 8'h3C, 8'h3C);
    push_line(1, 8'h81, 8'h81);
    push_line(2, 8'h00, 8'h00);
    frame(3);

    // Inverse attribute on cell 0 only
    vram_mem[12'h000] = 8'hC1;
    push_line(0, 8'hC3, 8'h3C);
    push_line(1, 8'h7E, 8'h81);
    frame(2);

    // Full frame: row advance, last row, rows past the text area
    vram_mem[12'h000] = 8'h41;
    vram_mem[12'h080] = 8'h41;
    vram_mem[12'hB80] = 8'h42;
    push_line(0,   8'h3C, 8'h3C);
    push_line(1,   8'h81, 8'h81);
    push_line(10,  8'h3C, 8'h00);
    push_line(239, 8'hF0, 8'h00);
    push_line(240, 8'h00, 8'h00);
    push_line(241, 8'h00, 8'h00);
    frame(242);

    // Half-rate pixel clock enable
    ce_div = 2;
    sync_en = 1'b1;
    push_line(0, 8'h3C, 8'h3C);
    push_line(1, 8'h81, 8'h81);
    frame(2);
    sync_en = 1'b0;
    ce_div = 1;

    // Reset in the middle of an active line, then a clean frame
    for (int v = 0; v < VBL; v++) drive_line(1'b1, (v == 1), -1);
    push_rd(0);
    drive_line(1'b0, 1'b0, -1);
    push_rd(1);
    drive_line(1'b0, 1'b0, 40);
    drive_line(1'b1, 1'b0, -1);
    rd_en = 1'b1; pix_en = 1'b1;
    push_line(0, 8'h3C, 8'h3C);
    push_line(1, 8'h81, 8'h81);
    frame(2);

    chk("rd_queue_left",  rd_q.size(), 32'd0);
    chk("pix_queue_left", pq.size(),   32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
